// File: rtl/sobel_tile_sched_pkg.sv
// -----------------------------------------------------------------------------
// sobel_pkg
//   Shared types and constants for the Sobel tile scheduler.
//   - sched_state_t : scheduler FSM states
//   - PIX_W         : pixel / edge byte width
//   - tile_bytes()  : number of bytes in an n x n tile
// -----------------------------------------------------------------------------
package sobel_pkg;

   localparam int PIX_W = 8;

   typedef enum logic [2:0] {
      FILL,
      LAUNCH,
      WAIT,
      DRAIN,
      FRAME_END
   } sched_state_t;

   function automatic int tile_bytes(input int n);
      return n * n;
   endfunction

endpackage

// File: rtl/sobel_tile_sched_if.sv
// -----------------------------------------------------------------------------
// sobel_tile_sched_if
//   Byte-stream handshakes around the Sobel tile scheduler.
//   Input stream  : in_valid / in_data  -> scheduler, in_ready  <- scheduler
//   Output stream : out_valid / out_data <- scheduler, out_ready -> scheduler
//   modport slave  : the scheduler side
//   modport master : the byte source / edge sink side
// -----------------------------------------------------------------------------
interface sobel_tile_sched_if;
   import sobel_pkg::*;

   logic             in_valid;
   logic [PIX_W-1:0] in_data;
   logic             in_ready;

   logic             out_valid;
   logic [PIX_W-1:0] out_data;
   logic             out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  out_valid,
      input  out_data,
      output out_ready
   );

endinterface

// File: rtl/sobel_tile_sched_wdog.sv
// -----------------------------------------------------------------------------
// sched_wdog
//   Watchdog for the core-wait phase: a down-counter reloaded by clr and
//   decremented while en is high. expire is high for the cycle in which the
//   counter sits at zero with en asserted, i.e. the TIMEOUT-th enabled cycle
//   after a clear.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     clr          : reload to TIMEOUT-1
//     en           : count enable (scheduler is waiting on the core)
//     expire       : combinational expiry flag, only while en
// -----------------------------------------------------------------------------
module sched_wdog #(
   parameter int TIMEOUT = 4096
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int            W    = $clog2(TIMEOUT) + 1;
   localparam logic [W-1:0]  LOAD = W'(TIMEOUT - 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= LOAD;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expire = en && (cnt == '0);

endmodule

// File: rtl/sobel_tile_sched.sv
// -----------------------------------------------------------------------------
// sobel_tile_sched
//   Sequencer between the UART byte stream and the sequential Sobel core.
//   Collects an N x N tile of raster-ordered pixel bytes, pulses core_start,
//   waits (with a watchdog) for core_done, then streams the N*N edge bytes
//   back out. Counts tiles per frame and pulses frame_done after the last
//   byte of the last tile.
//   Ports:
//     clk, reset_n    : clock, asynchronous active-low reset
//     px (slave)      : in_valid/in_data/in_ready pixel input,
//                       out_valid/out_data/out_ready edge output
//     tile_flat       : tile buffer to the core, byte k at [k*8 +: 8]
//     core_start      : one-cycle start pulse to the core
//     core_done       : core completion pulse (only honoured in WAIT)
//     core_edge_flat  : core edge map, same packing as tile_flat
//     frame_done      : one-cycle pulse once a full frame is drained
//     busy            : low only while idle in FILL with no byte taken
//     err_timeout     : sticky watchdog error
//     clear_err       : synchronous clear of err_timeout
// -----------------------------------------------------------------------------
module sobel_tile_sched
   import sobel_pkg::*;
#(
   parameter int N       = 16,
   parameter int TILES   = 4,
   parameter int TIMEOUT = 4096
) (
   input  logic                   clk,
   input  logic                   reset_n,
   sobel_tile_sched_if.slave      px,
   output logic [PIX_W*N*N-1:0]   tile_flat,
   output logic                   core_start,
   input  logic                   core_done,
   input  logic [PIX_W*N*N-1:0]   core_edge_flat,
   output logic                   frame_done,
   output logic                   busy,
   output logic                   err_timeout,
   input  logic                   clear_err
);

   localparam int                 NN       = tile_bytes(N);
   localparam int                 IDX_W    = $clog2(NN);
   localparam int                 TC_W     = $clog2(TILES) + 1;
   localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NN - 1);
   localparam logic [TC_W-1:0]    TC_LAST  = TC_W'(TILES - 1);

   sched_state_t       state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [TC_W-1:0]    tile_cnt;

   logic [PIX_W-1:0]   tile_mem [NN];
   logic [PIX_W-1:0]   out_mem  [NN];
   logic [PIX_W-1:0]   edge_b   [NN];

   logic               out_valid_q;
   logic [PIX_W-1:0]   out_data_q;

   logic               wd_clr;
   logic               wd_en;
   logic               wd_expire;

   assign idx_nxt = idx + IDX_W'(1);

   // in_ready is a pure state decode so it can never loop back through in_valid.
   assign px.in_ready  = (state == FILL);
   assign px.out_valid = out_valid_q;
   assign px.out_data  = out_data_q;

   // Flat <-> byte-array views of the tile and edge buffers.
   for (genvar g = 0; g < NN; g++) begin : g_pack
      assign tile_flat[g*PIX_W +: PIX_W] = tile_mem[g];
      assign edge_b[g]                   = core_edge_flat[g*PIX_W +: PIX_W];
   end

   // The watchdog is reloaded in LAUNCH so every WAIT starts a fresh window.
   assign wd_clr = (state == LAUNCH);
   assign wd_en  = (state == WAIT);

   sched_wdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .reset_n (reset_n),
      .clr     (wd_clr),
      .en      (wd_en),
      .expire  (wd_expire)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= FILL;
         idx         <= '0;
         tile_cnt    <= '0;
         tile_mem    <= '{default: '0};
         out_mem     <= '{default: '0};
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         core_start  <= 1'b0;
         frame_done  <= 1'b0;
         busy        <= 1'b0;
         err_timeout <= 1'b0;
      end else begin
         core_start <= 1'b0;
         frame_done <= 1'b0;

         // A fresh expiry outranks a clear arriving in the same cycle; a done
         // in the expiry cycle suppresses the error altogether.
         if (wd_expire && !core_done) begin
            err_timeout <= 1'b1;
         end else if (clear_err) begin
            err_timeout <= 1'b0;
         end

         case (state)
            FILL: begin
               if (px.in_valid) begin
                  tile_mem[idx] <= px.in_data;
                  busy          <= 1'b1;
                  if (idx == IDX_LAST) begin
                     idx        <= '0;
                     state      <= LAUNCH;
                     core_start <= 1'b1;
                  end else begin
                     idx <= idx_nxt;
                  end
               end
            end

            LAUNCH: begin
               state <= WAIT;
            end

            // tile_mem is not written here, so tile_flat stays stable while
            // the core walks through it.
            WAIT: begin
               if (core_done) begin
                  out_mem     <= edge_b;
                  out_data_q  <= edge_b[0];
                  out_valid_q <= 1'b1;
                  state       <= DRAIN;
               end else if (wd_expire) begin
                  // Still emit a full tile of zeros so downstream framing holds.
                  out_mem     <= '{default: '0};
                  out_data_q  <= '0;
                  out_valid_q <= 1'b1;
                  state       <= DRAIN;
               end
            end

            DRAIN: begin
               if (px.out_ready) begin
                  if (idx == IDX_LAST) begin
                     idx         <= '0;
                     out_valid_q <= 1'b0;
                     out_data_q  <= '0;
                     if (tile_cnt == TC_LAST) begin
                        tile_cnt   <= '0;
                        state      <= FRAME_END;
                        frame_done <= 1'b1;
                     end else begin
                        tile_cnt <= tile_cnt + TC_W'(1);
                        state    <= FILL;
                        busy     <= 1'b0;
                     end
                  end else begin
                     idx        <= idx_nxt;
                     out_data_q <= out_mem[idx_nxt];
                  end
               end
            end

            FRAME_END: begin
               state <= FILL;
               busy  <= 1'b0;
            end

            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sobel_tile_sched.sv
// -----------------------------------------------------------------------------
// tb_sobel_tile_sched
//   Directed bench for sobel_tile_sched with N=4, TILES=2, TIMEOUT=8.
//   The core is modelled inline: after core_start the bench waits a chosen
//   number of WAIT cycles, then pulses core_done with a known edge pattern.
// -----------------------------------------------------------------------------
module tb_sobel_tile_sched;
   import sobel_pkg::*;

   localparam int N       = 4;
   localparam int TILES   = 2;
   localparam int TIMEOUT = 8;
   localparam int NN      = 16;
   localparam int TW      = 128;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          core_done = 1'b0;
   logic          clear_err = 1'b0;
   logic [TW-1:0] core_edge_flat = '0;
   logic [TW-1:0] tile_flat;
   logic          core_start;
   logic          frame_done;
   logic          busy;
   logic          err_timeout;

   int n_checks = 0;
   int n_fail   = 0;

   sobel_tile_sched_if px ();

   sobel_tile_sched #(
      .N       (N),
      .TILES   (TILES),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .px             (px),
      .tile_flat      (tile_flat),
      .core_start     (core_start),
      .core_done      (core_done),
      .core_edge_flat (core_edge_flat),
      .frame_done     (frame_done),
      .busy           (busy),
      .err_timeout    (err_timeout),
      .clear_err      (clear_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL tb_timeout got=hung exp=finish");
      $fatal(1, "bench time limit");
   end

   task automatic check_eq(input string tag, input logic [TW-1:0] got, input logic [TW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Byte k = base + k*step, packed with byte 0 in the LSBs.
   function automatic logic [TW-1:0] pat(input logic [7:0] base, input logic [7:0] step);
      logic [TW-1:0] v;
      logic [7:0]    b;
      v = '0;
      b = base;
      for (int k = 0; k < NN; k++) begin
         v = {b, v[TW-1:8]};
         b = b + step;
      end
      return v;
   endfunction

   // Feed 16 bytes base+k; gap_mask bit set = idle cycle. Ends at the LAUNCH sample.
   task automatic feed_tile(input logic [7:0] base, input logic [15:0] gap_mask);
      int k;
      int cyc;
      int bad;
      k = 0; cyc = 0; bad = 0;
      while (k < NN && cyc < 100) begin
         if (core_start !== 1'b0 || px.out_valid !== 1'b0 || px.in_ready !== 1'b1) bad++;
         if (gap_mask[4'(cyc)]) begin
            px.in_valid = 1'b0;
         end else begin
            px.in_valid = 1'b1;
            px.in_data  = base + 8'(k);
         end
         tick();
         if (px.in_valid) k++;
         cyc++;
      end
      px.in_valid = 1'b0;
      check_eq("fill_count", 128'(k), 128'(NN));
      check_eq("fill_quiet", 128'(bad), 128'(0));
      check_eq("start_pulse", 128'(core_start), 128'(1));
      check_eq("launch_in_ready", 128'(px.in_ready), 128'(0));
      check_eq("tile_flat", tile_flat, pat(base, 8'd1));
   endtask

   // Called at the LAUNCH sample; core_done is raised in WAIT cycle n.
   task automatic core_respond(input int n, input logic [TW-1:0] edge_map, input logic [TW-1:0] exp_tile);
      int bad;
      bad = 0;
      core_edge_flat = edge_map;
      tick();
      for (int i = 1; i <= n; i++) begin
         if (core_start !== 1'b0 || tile_flat !== exp_tile || px.out_valid !== 1'b0 || busy !== 1'b1) bad++;
         if (i == n) core_done = 1'b1;
         tick();
         core_done = 1'b0;
      end
      check_eq("wait_quiet", 128'(bad), 128'(0));
      check_eq("out_valid_after_done", 128'(px.out_valid), 128'(1));
      check_eq("first_edge_byte", 128'(px.out_data), 128'(edge_map[7:0]));
   endtask

   // Drain nbytes; ready_mask bit set = stall. poke raises core_done in the first DRAIN cycle.
   task automatic drain_tile(input logic [7:0] base, input logic [7:0] step, input logic [15:0] ready_mask,
                             input int nbytes, input logic poke);
      int         got;
      int         cyc;
      int         bad_stable;
      logic [7:0] exp_b;
      logic [7:0] prev_d;
      logic       prev_stall;
      got = 0; cyc = 0; bad_stable = 0;
      exp_b = base; prev_d = '0; prev_stall = 1'b0;
      while (got < nbytes && cyc < 200) begin
         if (prev_stall && (px.out_valid !== 1'b1 || px.out_data !== prev_d)) bad_stable++;
         px.out_ready = !ready_mask[4'(cyc)];
         if (cyc == 0) core_done = poke;
         if (px.out_valid && px.out_ready) begin
            check_eq("drain_byte", 128'(px.out_data), 128'(exp_b));
            exp_b = exp_b + step;
            got++;
         end
         prev_stall = px.out_valid && !px.out_ready;
         prev_d     = px.out_data;
         tick();
         core_done = 1'b0;
         cyc++;
      end
      px.out_ready = 1'b0;
      check_eq("drain_count", 128'(got), 128'(nbytes));
      check_eq("drain_stable", 128'(bad_stable), 128'(0));
      if (ready_mask == 16'h0000) check_eq("drain_cycles", 128'(cyc), 128'(nbytes));
   endtask

   initial begin
      px.in_valid  = 1'b0;
      px.in_data   = '0;
      px.out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check_eq("rst_in_ready", 128'(px.in_ready), 128'(1));
      check_eq("rst_out_valid", 128'(px.out_valid), 128'(0));
      check_eq("rst_busy", 128'(busy), 128'(0));
      check_eq("rst_core_start", 128'(core_start), 128'(0));
      check_eq("rst_err", 128'(err_timeout), 128'(0));
      check_eq("rst_tile", tile_flat, 128'(0));
      reset_n = 1'b1;
      tick();
      check_eq("idle_busy", 128'(busy), 128'(0));

      // Tile 1: continuous input, core answers with all-FF, full-rate drain
      feed_tile(8'h00, 16'h0000);
      check_eq("launch_busy", 128'(busy), 128'(1));
      core_respond(6, pat(8'hFF, 8'h00), pat(8'h00, 8'd1));
      drain_tile(8'hFF, 8'h00, 16'h0000, NN, 1'b0);
      check_eq("t1_no_frame_done", 128'(frame_done), 128'(0));
      check_eq("t1_back_to_fill", 128'(px.in_ready), 128'(1));
      check_eq("t1_out_idle", 128'(px.out_valid), 128'(0));
      check_eq("t1_busy_low", 128'(busy), 128'(0));

      // Tile 2: input gaps, done coincides with watchdog expiry, 50% backpressure
      feed_tile(8'h10, 16'h5A31);
      core_respond(8, pat(8'hA0, 8'd1), pat(8'h10, 8'd1));
      check_eq("coincide_no_err", 128'(err_timeout), 128'(0));
      drain_tile(8'hA0, 8'd1, 16'hA5A5, NN, 1'b0);
      check_eq("frame_done_pulse", 128'(frame_done), 128'(1));
      check_eq("frame_end_busy", 128'(busy), 128'(1));
      check_eq("frame_end_in_ready", 128'(px.in_ready), 128'(0));
      tick();
      check_eq("frame_done_single", 128'(frame_done), 128'(0));
      check_eq("after_frame_fill", 128'(px.in_ready), 128'(1));

      // Tile 3: core never answers -> timeout after 8 WAIT cycles, zeros emitted
      feed_tile(8'h40, 16'h0000);
      core_edge_flat = pat(8'h99, 8'd1);
      begin
         int bad;
         bad = 0;
         for (int i = 1; i <= TIMEOUT; i++) begin
            tick();
            if (err_timeout !== 1'b0 || px.out_valid !== 1'b0) bad++;
         end
         check_eq("wait_before_timeout", 128'(bad), 128'(0));
      end
      tick();
      check_eq("err_set", 128'(err_timeout), 128'(1));
      check_eq("timeout_out_valid", 128'(px.out_valid), 128'(1));
      drain_tile(8'h00, 8'h00, 16'h3C3C, NN, 1'b1);
      check_eq("err_sticky", 128'(err_timeout), 128'(1));
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      check_eq("err_cleared", 128'(err_timeout), 128'(0));

      // Tile 4: reset while draining at byte 7
      feed_tile(8'h50, 16'h0000);
      core_respond(2, pat(8'h55, 8'h00), pat(8'h50, 8'd1));
      drain_tile(8'h55, 8'h00, 16'h0000, 7, 1'b0);
      check_eq("pre_reset_valid", 128'(px.out_valid), 128'(1));
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_out_valid", 128'(px.out_valid), 128'(0));
      check_eq("mid_rst_out_data", 128'(px.out_data), 128'(0));
      check_eq("mid_rst_in_ready", 128'(px.in_ready), 128'(1));
      check_eq("mid_rst_busy", 128'(busy), 128'(0));
      check_eq("mid_rst_tile", tile_flat, 128'(0));
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      check_eq("post_rst_quiet", 128'(px.out_valid), 128'(0));

      // Tile 5: restarts from idx 0 with tile_cnt 0, so no frame_done afterwards
      feed_tile(8'h60, 16'h0000);
      core_respond(3, pat(8'hC0, 8'd1), pat(8'h60, 8'd1));
      drain_tile(8'hC0, 8'd1, 16'h0000, NN, 1'b0);
      check_eq("post_rst_no_frame_done", 128'(frame_done), 128'(0));
      check_eq("post_rst_fill", 128'(px.in_ready), 128'(1));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
